// File: rtl/ethernet_inet_checksum_engine_pkg.sv
// Shared constants and helpers for the RFC 1071 checksum engine and its users.
package eth_csum_pkg;

  localparam int unsigned CSUM_W         = 16;
  localparam int unsigned ETH_HDR_BYTES  = 14;
  localparam int unsigned IPV4_HDR_BYTES = 20;
  localparam int unsigned ICMP_SKIP      = ETH_HDR_BYTES + IPV4_HDR_BYTES;
  localparam int unsigned UDP_SKIP       = 34;
  localparam int unsigned FOLD_ACC_W     = 32;

  typedef enum logic {StIdle, StSum} csum_state_e;

  // First fold stage: low half plus high half, carry kept in bit 16.
  function automatic logic [CSUM_W:0] csum_fold(input logic [FOLD_ACC_W-1:0] acc);
    return {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
  endfunction

endpackage

// File: rtl/ethernet_inet_checksum_engine_word_adder.sv
// Combinational masked big-endian 16-bit word sum across one stream beat.
module eth_csum_word_adder
  import eth_csum_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned SUM_W  = 32
) (
  input  logic [DATA_W-1:0]   i_data,
  input  logic [DATA_W/8-1:0] i_mask,
  output logic [SUM_W-1:0]    o_sum
);

  localparam int unsigned NWORDS = DATA_W / CSUM_W;

  logic [CSUM_W-1:0] w_words [NWORDS];

  // Even byte is the high half of each word; masked bytes contribute zero.
  for (genvar j = 0; j < NWORDS; j++) begin : g_word
    assign w_words[j] = {i_mask[2*j]   ? i_data[16*j +: 8]   : 8'h00,
                         i_mask[2*j+1] ? i_data[16*j+8 +: 8] : 8'h00};
  end

  always_comb begin
    o_sum = '0;
    for (int j = 0; j < NWORDS; j++) begin
      o_sum = o_sum + SUM_W'(w_words[j]);
    end
  end

endmodule

// File: rtl/ethernet_inet_checksum_engine.sv
// Passive AXI-Stream RX checksum monitor with header skip, seed and 2-stage fold.
// Define ETH_CSUM_VERIFY_EN to build the zero-result compare driving o_csum_ok.
module ethernet_inet_checksum_engine
  import eth_csum_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned SKIP_BYTES = 34,
  parameter int unsigned ACC_W      = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [DATA_W-1:0]   i_s_axis_tdata,
  input  logic [DATA_W/8-1:0] i_s_axis_tkeep,
  input  logic                i_s_axis_tvalid,
  input  logic                i_s_axis_tready,
  input  logic                i_s_axis_tlast,
  input  logic [15:0]         i_seed,
  input  logic                i_seed_valid,
  input  logic                i_abort,
  output logic [15:0]         o_csum,
  output logic                o_csum_valid,
  output logic                o_csum_ok
);

  localparam int unsigned NBYTES = DATA_W / 8;

  csum_state_e         r_state;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    r_snap;
  logic                r_snap_v;
  logic [CSUM_W:0]     r_f1;
  logic                r_f1_v;
  logic [15:0]         r_seed;
  logic [15:0]         r_byte_cnt;

  logic                w_accept;
  logic                w_abort;
  logic                w_end;
  logic [15:0]         w_seed_eff;
  logic [ACC_W-1:0]    w_base;
  logic [ACC_W-1:0]    w_beat_sum;
  logic [NBYTES-1:0]   w_mask;
  logic [16:0]         w_cnt_inc;
  logic [CSUM_W:0]     w_f1;
  logic [CSUM_W-1:0]   w_csum_next;

  assign w_accept   = i_s_axis_tvalid & i_s_axis_tready;
  // Abort only matters while a frame is open or one is starting this cycle.
  assign w_abort    = i_abort & ((r_state == StSum) | w_accept);
  assign w_end      = w_accept & i_s_axis_tlast & ~i_abort;
  assign w_seed_eff = i_seed_valid ? i_seed : r_seed;
  assign w_base     = (r_state == StIdle) ? ACC_W'(w_seed_eff) : r_acc;
  assign w_cnt_inc  = {1'b0, r_byte_cnt} + 17'(NBYTES);

  always_comb begin
    w_mask = '0;
    for (int k = 0; k < NBYTES; k++) begin
      w_mask[k] = i_s_axis_tkeep[k] && ((17'(r_byte_cnt) + 17'(k)) >= 17'(SKIP_BYTES));
    end
  end

  eth_csum_word_adder #(
    .DATA_W (DATA_W),
    .SUM_W  (ACC_W)
  ) u_word_adder (
    .i_data (i_s_axis_tdata),
    .i_mask (w_mask),
    .o_sum  (w_beat_sum)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_acc      <= '0;
      r_seed     <= '0;
      r_byte_cnt <= '0;
    end else if (w_abort || w_end) begin
      r_state    <= StIdle;
      r_acc      <= '0;
      r_seed     <= '0;
      r_byte_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_state    <= StSum;
        r_acc      <= w_base + w_beat_sum;
        r_byte_cnt <= w_cnt_inc[16] ? 16'hFFFF : w_cnt_inc[15:0];
      end
      if (i_seed_valid) begin
        r_seed <= i_seed;
      end
    end
  end

  // Fold runs on a snapshot so the accumulator is free for the next frame at once.
  assign w_f1        = {1'b0, r_snap[15:0]} + (CSUM_W+1)'(r_snap[ACC_W-1:16]);
  assign w_csum_next = ~(r_f1[15:0] + 16'(r_f1[16]));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_snap       <= '0;
      r_snap_v     <= 1'b0;
      r_f1         <= '0;
      r_f1_v       <= 1'b0;
      o_csum       <= '0;
      o_csum_valid <= 1'b0;
    end else begin
      r_snap_v     <= w_end;
      r_f1_v       <= r_snap_v;
      o_csum_valid <= r_f1_v;
      if (w_end) begin
        r_snap <= w_base + w_beat_sum;
      end
      if (r_snap_v) begin
        r_f1 <= w_f1;
      end
      if (r_f1_v) begin
        o_csum <= w_csum_next;
      end
    end
  end

`ifdef ETH_CSUM_VERIFY_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_csum_ok <= 1'b0;
    end else if (r_f1_v) begin
      o_csum_ok <= (w_csum_next == 16'h0000);
    end
  end
`else
  assign o_csum_ok = 1'b0;
`endif

endmodule

// File: tb/tb_ethernet_inet_checksum_engine.sv
// Randomised self-checking bench: two engines (skip 0 and skip 34) watch one stream.
// Expected o_csum_ok follows ETH_CSUM_VERIFY_EN when that macro is defined.
module tb_ethernet_inet_checksum_engine;
  import eth_csum_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid, tready, tlast;
  logic [15:0] seed;
  logic        seed_v, abort;
  logic [15:0] csum0, csum34;
  logic        v0, v34, ok0, ok34;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef logic [7:0] bytes_t [$];
  typedef struct {int due; logic [15:0] c0; logic [15:0] c34;} exp_t;
  exp_t        exp_q [$];
  exp_t        e;
  logic [15:0] last0 = 16'h0;
  logic [15:0] last34 = 16'h0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ethernet_inet_checksum_engine #(.DATA_W(64), .SKIP_BYTES(0), .ACC_W(32)) u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_s_axis_tdata(tdata), .i_s_axis_tkeep(tkeep),
    .i_s_axis_tvalid(tvalid), .i_s_axis_tready(tready), .i_s_axis_tlast(tlast),
    .i_seed(seed), .i_seed_valid(seed_v), .i_abort(abort),
    .o_csum(csum0), .o_csum_valid(v0), .o_csum_ok(ok0)
  );

  ethernet_inet_checksum_engine #(.DATA_W(64), .SKIP_BYTES(34), .ACC_W(32)) u_dut34 (
    .i_clk(clk), .i_reset(rst), .i_s_axis_tdata(tdata), .i_s_axis_tkeep(tkeep),
    .i_s_axis_tvalid(tvalid), .i_s_axis_tready(tready), .i_s_axis_tlast(tlast),
    .i_seed(seed), .i_seed_valid(seed_v), .i_abort(abort),
    .o_csum(csum34), .o_csum_valid(v34), .o_csum_ok(ok34)
  );

  // Reference: plain RFC 1071 sum over the byte list with end-around carry.
  function automatic logic [15:0] model_csum(input bytes_t b, input int skip,
                                             input logic [15:0] s);
    longint unsigned sum = longint'(s);
    for (int i = skip; i < b.size(); i++) begin
      if (i % 2 == 0) sum += longint'(b[i]) << 8;
      else            sum += longint'(b[i]);
    end
    while ((sum >> 16) != 0) sum = (sum & 64'hFFFF) + (sum >> 16);
    return ~(16'(sum));
  endfunction

  function automatic bytes_t rand_bytes(input int n);
    bytes_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [63:0] d, input logic [7:0] k, input logic v, input logic r,
                      input logic l, input logic [15:0] s, input logic sv, input logic ab);
    tdata = d; tkeep = k; tvalid = v; tready = r; tlast = l;
    seed = s; seed_v = sv; abort = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(64'h0, 8'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  // seed_mode: 0 none, 1 on first beat, 2 preloaded one idle cycle before.
  task automatic send_frame(input bytes_t b, input logic [15:0] s, input int seed_mode,
                            input bit gaps, input int c0_exp, input int c34_exp);
    logic [15:0] ms;
    logic [63:0] d;
    logic [7:0]  k;
    int          nb;
    exp_t        x;
    ms = (seed_mode != 0) ? s : 16'h0;
    if (seed_mode == 2) step(64'h0, 8'h0, 1'b0, 1'b1, 1'b0, s, 1'b1, 1'b0);
    nb = (b.size() + 7) / 8;
    for (int j = 0; j < nb; j++) begin
      d = '0;
      k = '0;
      for (int i = 0; i < 8; i++) begin
        if (8*j + i < b.size()) begin
          d[8*i +: 8] = b[8*j + i];
          k[i] = 1'b1;
        end
      end
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          if ($urandom_range(0, 1) == 1)
            step({$urandom, $urandom}, 8'hFF, 1'b1, 1'b0, 1'($urandom), 16'h0, 1'b0, 1'b0);
          else
            step({$urandom, $urandom}, 8'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        end
      end
      step(d, k, 1'b1, 1'b1, (j == nb - 1), s, (seed_mode == 1 && j == 0), 1'b0);
    end
    x.due = cyc + 2;
    x.c0  = (c0_exp  < 0) ? model_csum(b, 0, ms)  : 16'(c0_exp);
    x.c34 = (c34_exp < 0) ? model_csum(b, 34, ms) : 16'(c34_exp);
    exp_q.push_back(x);
  endtask

  task automatic abort_frame(input int beats, input bit with_last);
    for (int j = 0; j < beats; j++)
      step({$urandom, $urandom}, 8'hFF, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    step({$urandom, $urandom}, 8'hFF, 1'b1, 1'b1, with_last, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("drain_pending", 16'(exp_q.size()), 16'h0);
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk("valid0", 16'(v0), 16'h1);
        chk("valid34", 16'(v34), 16'h1);
        chk("csum0", csum0, e.c0);
        chk("csum34", csum34, e.c34);
`ifdef ETH_CSUM_VERIFY_EN
        chk("ok0", 16'(ok0), 16'(e.c0 == 16'h0));
        chk("ok34", 16'(ok34), 16'(e.c34 == 16'h0));
`else
        chk("ok0", 16'(ok0), 16'h0);
        chk("ok34", 16'(ok34), 16'h0);
`endif
        last0  = e.c0;
        last34 = e.c34;
      end else begin
        chk("idle_valid0", 16'(v0), 16'h0);
        chk("idle_valid34", 16'(v34), 16'h0);
        chk("hold_csum0", csum0, last0);
        chk("hold_csum34", csum34, last34);
      end
    end
  end

  initial begin
    bytes_t      b;
    logic [15:0] c;
    rst = 1'b1;
    tdata = '0; tkeep = '0; tvalid = 1'b0; tready = 1'b1; tlast = 1'b0;
    seed = '0; seed_v = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_csum0", csum0, 16'h0);
    chk("rst_csum34", csum34, 16'h0);
    chk("rst_valid0", 16'(v0), 16'h0);
    chk("rst_valid34", 16'(v34), 16'h0);
    chk("rst_ok0", 16'(ok0), 16'h0);
    chk("rst_ok34", 16'(ok34), 16'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    idle(2);

    b = {8'h08, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 8'h01};
    send_frame(b, 16'h0, 0, 1'b0, 'hE5CA, 'hFFFF);
    idle(1);
    b = {8'hFF, 8'hFF, 8'h00, 8'h01};
    send_frame(b, 16'h0, 0, 1'b0, 'hFFFE, 'hFFFF);
    idle(1);
    b = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAB};
    send_frame(b, 16'h0, 0, 1'b0, 'h54FF, 'hFFFF);
    idle(1);

    b = rand_bytes(34);
    b.push_back(8'h22);
    b.push_back(8'h22);
    send_frame(b, 16'h1111, 1, 1'b0, -1, 'hCCCC);
    b = rand_bytes(34);
    b.push_back(8'h22);
    b.push_back(8'h22);
    send_frame(b, 16'h1111, 2, 1'b1, -1, 'hCCCC);

    // Back-to-back with a single-beat frame immediately after a multi-beat one.
    send_frame(rand_bytes(16), 16'h0, 0, 1'b0, -1, -1);
    send_frame(rand_bytes(2), 16'h0, 0, 1'b0, -1, -1);
    send_frame(rand_bytes(5), 16'h4321, 1, 1'b0, -1, -1);
    idle(1);

    abort_frame(2, 1'b0);
    b = {8'h08, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 8'h01};
    send_frame(b, 16'h0, 0, 1'b0, 'hE5CA, 'hFFFF);
    abort_frame(1, 1'b1);
    b = {8'hFF, 8'hFF, 8'h00, 8'h01};
    send_frame(b, 16'h0, 0, 1'b0, 'hFFFE, 'hFFFF);
    idle(1);

    b = {8'h45, 8'h00, 8'h00, 8'h1C, 8'hAB, 8'hCD, 8'h40, 8'h00, 8'h40, 8'h01};
    c = model_csum(b, 0, 16'h0);
    b.push_back(c[15:8]);
    b.push_back(c[7:0]);
    send_frame(b, 16'h0, 0, 1'b0, 'h0000, -1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) abort_frame($urandom_range(1, 3), 1'($urandom));
      send_frame(rand_bytes($urandom_range(1, 80)), 16'($urandom), $urandom_range(0, 2),
                 1'($urandom), -1, -1);
      idle($urandom_range(0, 2));
    end
    drain();

    // Reset while a frame sits in the fold pipeline: its result must never appear.
    send_frame(rand_bytes(6), 16'h0, 0, 1'b0, -1, -1);
    rst = 1'b1;
    exp_q.delete();
    last0  = 16'h0;
    last34 = 16'h0;
    idle(3);
    chk("mid_rst_csum0", csum0, 16'h0);
    chk("mid_rst_valid0", 16'(v0), 16'h0);
    chk("mid_rst_csum34", csum34, 16'h0);
    rst = 1'b0;
    idle(3);
    b = {8'h08, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 8'h01};
    send_frame(b, 16'h0, 0, 1'b0, 'hE5CA, 'hFFFF);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ethernet_inet_checksum_engine.md
Name: ethernet_inet_checksum_engine

Overview:
Parametrised RFC 1071 one's-complement checksum engine that passively monitors an AXI-Stream RX frame. It skips a configurable byte prefix (Ethernet/IP headers), optionally starts from a pseudo-header seed, and accumulates 16-bit big-endian words. It emits a folded, complemented checksum through a 2-stage fold pipeline, so back-to-back frames need no idle cycles. It generalises the ICMP-only 64-bit summer used by the ICMP responder and will also serve the UDP/TCP paths.

Parameters:
DATA_W, 64, stream width in bits; multiple of 16, range 16..512
SKIP_BYTES, 34, frame bytes excluded before summing; must be even
ACC_W, 32, accumulator width; must satisfy ACC_W >= 16 + clog2(max frame words + 1)

Ports:
i_clk  in  1  clock
i_reset  in  1  async active-high reset
i_s_axis_tdata  in  DATA_W  frame data; byte k = tdata[8k+7:8k], byte 0 first on the wire
i_s_axis_tkeep  in  DATA_W/8  byte enables; contiguous from bit 0
i_s_axis_tvalid  in  1  beat valid
i_s_axis_tready  in  1  sink ready (monitored, not driven)
i_s_axis_tlast  in  1  last beat of frame
i_seed  in  16  initial sum (pseudo-header), 0 if unused
i_seed_valid  in  1  load i_seed for the next/current frame
i_abort  in  1  discard the frame in progress
o_csum  out  16  complemented checksum
o_csum_valid  out  1  one-cycle strobe qualifying o_csum/o_csum_ok
o_csum_ok  out  1  verify result (see Optional Feature)

Behaviour:
- Reset (asynchronous, i_reset high, i_clk domain): accumulator=0, byte counter=0, seed reg=0, state IDLE; o_csum=0, o_csum_valid=0, o_csum_ok=0.
- Handshake: beat accepted when tvalid & tready. Non-accepted cycles change nothing.
- Byte pairing: byte 2j is the high byte and byte 2j+1 the low byte of word j. A byte is counted only if tkeep=1 and frame_byte_index >= SKIP_BYTES. A masked byte contributes 0.
- tkeep is all-ones on non-last beats. An odd count on the tlast beat zero-pads the low byte, e.g. lone 0xAB becomes word 0xAB00.
- Beat sum: adder tree of DATA_W/16 words, zero-extended to ACC_W, added to the accumulator in the same cycle.
- FSM states:
  - IDLE -> SUM on the first accepted beat.
  - SUM -> IDLE on an accepted tlast beat or on i_abort.
  - On frame start the accumulator loads seed_reg + beat_sum. seed_reg loads from i_seed when i_seed_valid=1, otherwise holds its value.
  - i_seed_valid coincident with the first beat uses i_seed directly.
  - seed_reg clears to 0 after each frame completes or aborts.
- Frame byte counter: 16 bits, saturating at 0xFFFF, cleared at tlast/abort.
- Fold pipeline on tlast (snapshot, independent of the accumulator):
  - Cycle N (tlast accepted): snap <= acc + beat_sum; the accumulator is free for the next frame at N+1.
  - N+1: f1 <= snap[15:0] + snap[ACC_W-1:16] (17 bits).
  - N+2: o_csum <= ~(f1[15:0] + f1[16]) and o_csum_valid=1 for that cycle only.
  - A frame ending every cycle yields a valid every cycle.
- Single-beat frame (tlast on the first beat): still latency 2, and the seed applies.
- i_abort in SUM: accumulator and counter clear and no output is produced. If it coincides with a tlast beat, abort wins. Frames already in the fold pipeline complete normally.
- The header is fully skipped if the frame is shorter than SKIP_BYTES. The result is ~seed, still reported.
- o_csum holds its value between strobes.

Optional Feature:
Macro ETH_CSUM_VERIFY_EN.
- Defined: at N+2, o_csum_ok = (o_csum next value == 16'h0000), i.e. the embedded checksum is correct. Only meaningful when the frame includes its checksum field.
- Undefined: o_csum_ok tied 0 and no compare logic is built. The port is kept for a stable interface.

Decomposition:
- Shared package eth_csum_pkg holds:
  - CSUM_W=16
  - localparams ETH_HDR_BYTES=14, IPV4_HDR_BYTES=20, ICMP_SKIP=34, UDP_SKIP=34
  - function csum_fold(ACC_W-bit) -> 17-bit, for bench reuse
- One natural sub-module, eth_csum_word_adder: a combinational masked big-endian word-sum tree, parametrised by DATA_W. The FSM, counter and fold pipeline stay in the top.

Test Plan:
- ICMP, DATA_W=64, SKIP=0: words 0x0800,0x0000,0x1234,0x0001 in one tlast beat -> o_csum=0xE5CA, valid 2 cycles after the beat.
- Carry fold: words 0xFFFF,0x0001 -> sum 0x10000 -> o_csum=0xFFFE.
- Odd tail: second beat tkeep=0x01, byte 0xAB, nothing else summed -> o_csum=0x54FF.
- Seed + skip: SKIP=34, i_seed=0x1111, payload word 0x2222 after 34 header bytes -> o_csum=0xCCCC. Garbage header bytes have no effect.
- Back-to-back: frame A ends cycle N, frame B single beat at N+1 -> valid at N+2 (A) and N+3 (B). Also check tvalid gaps and tready=0 stalls.
- Abort/reset: i_abort mid-frame -> no valid and the next frame sums cleanly. i_reset mid-fold -> valid never asserts and outputs are 0. With ETH_CSUM_VERIFY_EN, a frame including a correct checksum -> o_csum_ok=1.
